// File: rtl/alu4_pkg.sv
// Shared definitions for the 4-bit ALU checker: opcodes, FSM encoding, vector layout
// and the golden reference function used by every consumer of the ALU model.
package alu4_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Field order matches the first-fail record layout {A,B,S,C,Co}.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] s;
        logic [3:0] c;
        logic       co;
    } vec_t;

    // Returns {Co, C}; subtract is A + ~B + 1 so Co=1 means no borrow.
    function automatic logic [4:0] alu4_golden_fn(input logic [3:0] a,
                                                  input logic [3:0] b,
                                                  input logic [1:0] s);
        logic [4:0] r;
        r = 5'd0;
        case (s)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + 5'd1;
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu4_golden.sv
// Purely combinational reference ALU producing {Co, C}; zero latency, no flow control,
// kept standalone so other benches can reuse it.
module alu4_golden
    import alu4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] s,
    output logic [4:0] res
);

    always_comb begin
        res = alu4_golden_fn(a, b, s);
    end

endmodule

// File: rtl/alu4_checker.sv
// Pipelined ALU result checker: latency 2 clocks from accept to chk_valid, one vector per clock.
// in_ready drops (HALT) the cycle after a reported mismatch when STOP_ON_FAIL=1; vectors already in flight drain.
module alu4_checker
    import alu4_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic [1:0]       S,
    input  logic [3:0]       C,
    input  logic             Co,
    output logic             chk_valid,
    output logic             chk_fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             halted,
    output logic [15:0]      ff_vec
);

    state_t     state;
    state_t     state_nxt;
    logic       sync_clr;
    logic       take;
    logic       s1_vld;
    vec_t       s1;
    logic [4:0] s1_exp;
    logic       s2_vld;
    vec_t       s2;
    logic [4:0] s2_exp;
    logic       mismatch;

    assign sync_clr = rst | clr;
    assign take     = in_valid & in_ready;
    assign mismatch = ({s2.co, s2.c} != s2_exp);

    alu4_golden u_golden (
        .a   (s1.a),
        .b   (s1.b),
        .s   (s1.s),
        .res (s1_exp)
    );

    // Datapath registers carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (take) begin
            s1 <= vec_t'({A, B, S, C, Co});
        end
        if (s1_vld) begin
            s2     <= s1;
            s2_exp <= s1_exp;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            s1_vld    <= 1'b0;
            s2_vld    <= 1'b0;
            chk_valid <= 1'b0;
            chk_fail  <= 1'b0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            ff_vec    <= '0;
        end else begin
            s1_vld    <= take;
            s2_vld    <= s1_vld;
            chk_valid <= s2_vld;
            chk_fail  <= s2_vld & mismatch;
            if (s2_vld && !mismatch && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (s2_vld && mismatch) begin
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
                // Saturating counter never returns to zero, so zero marks "no failure yet".
                if (fail_cnt == '0) begin
                    ff_vec <= {s2, 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_clr) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (STOP_ON_FAIL && chk_valid && chk_fail) begin
                    state_nxt = ST_HALT;
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_RUN);
        halted   = (state == ST_HALT);
    end

endmodule

// File: tb/tb_alu4_checker.sv
// Scoreboard bench for alu4_checker: one halting and one free-running instance share the stimulus.
module tb_alu4_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] A = 4'd0;
    logic [3:0] B = 4'd0;
    logic [1:0] S = 2'd0;
    logic [3:0] C = 4'd0;
    logic       Co = 1'b0;

    logic        in_ready, chk_valid, chk_fail, halted;
    logic [7:0]  pass_cnt, fail_cnt;
    logic [15:0] ff_vec;
    logic        nh_in_ready, nh_chk_valid, nh_chk_fail, nh_halted;
    logic [7:0]  nh_pass_cnt, nh_fail_cnt;
    logic [15:0] nh_ff_vec;

    always #5 clk = ~clk;

    alu4_checker #(.CNT_W(8), .STOP_ON_FAIL(1'b1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .S(S), .C(C), .Co(Co),
        .chk_valid(chk_valid), .chk_fail(chk_fail), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .halted(halted), .ff_vec(ff_vec)
    );

    alu4_checker #(.CNT_W(8), .STOP_ON_FAIL(1'b0)) dut_nh (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(nh_in_ready),
        .A(A), .B(B), .S(S), .C(C), .Co(Co),
        .chk_valid(nh_chk_valid), .chk_fail(nh_chk_fail), .pass_cnt(nh_pass_cnt),
        .fail_cnt(nh_fail_cnt), .halted(nh_halted), .ff_vec(nh_ff_vec)
    );

    typedef struct {
        logic fail;
        int   edge_n;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        case (s)
            2'd0:    return 5'(ai + bi);
            2'd1:    return {(ai >= bi), 4'(ai - bi)};
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Pushes an expectation only when the halting instance will take the vector.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                         input logic [3:0] c, input logic co);
        exp_t e;
        @(negedge clk);
        A = a; B = b; S = s; C = c; Co = co;
        in_valid = 1'b1;
        if (in_ready && !rst && !clr) begin
            e.fail   = (model(a, b, s) != {co, c});
            e.edge_n = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        in_valid = 1'b0;
        clr = 1'b1;
        sb.delete();
        @(negedge clk);
        clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_valid === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_chk_valid: got chk_valid=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (chk_fail !== mon_e.fail || cyc != mon_e.edge_n + 2)
                    $display("FAIL chk_result: got chk_fail=%b at edge %0d, required chk_fail=%b at edge %0d",
                             chk_fail, cyc, mon_e.fail, mon_e.edge_n + 2);
                else
                    n_pass++;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else n_pass++;
        n_total++; if (chk_valid !== 1'b0) $display("FAIL reset_chk_valid: got %b required 0", chk_valid); else n_pass++;
        n_total++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0)
            $display("FAIL reset_counts: got %0d/%0d required 0/0", pass_cnt, fail_cnt); else n_pass++;
        n_total++; if (halted !== 1'b0 || ff_vec !== 16'h0)
            $display("FAIL reset_halt_ff: got halted=%b ff_vec=%h required 0/0000", halted, ff_vec); else n_pass++;
    endtask

    task automatic test_add();
        drive(4'b1010, 4'b0111, 2'b00, 4'b0001, 1'b1);
        idle();
        drain();
        n_total++; if (sb.size() != 0) $display("FAIL add_drain: got %0d pending required 0", sb.size()); else n_pass++;
        n_total++; if (pass_cnt !== 8'd1 || fail_cnt !== 8'd0)
            $display("FAIL add_counts: got %0d/%0d required 1/0", pass_cnt, fail_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b;
        logic [1:0] s;
        logic [4:0] g;
        drive(4'b1010, 4'b0011, 2'b00, 4'b1101, 1'b0);
        drive(4'b1010, 4'b0011, 2'b01, 4'b0111, 1'b1);
        drive(4'b1010, 4'b0011, 2'b10, 4'b0010, 1'b0);
        drive(4'b1010, 4'b0011, 2'b11, 4'b1011, 1'b0);
        for (int i = 0; i < 20; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            s = 2'($urandom_range(0, 3));
            g = model(a, b, s);
            drive(a, b, s, g[3:0], g[4]);
        end
        idle();
        drain();
        n_total++; if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending required 0", sb.size()); else n_pass++;
        n_total++; if (pass_cnt !== 8'd25 || fail_cnt !== 8'd0)
            $display("FAIL b2b_counts: got %0d/%0d required 25/0", pass_cnt, fail_cnt); else n_pass++;
    endtask

    task automatic test_fail_halt();
        drive(4'b1010, 4'b0011, 2'b01, 4'b0111, 1'b0);
        drive(4'b1010, 4'b0011, 2'b00, 4'b1101, 1'b0);
        drive(4'b1010, 4'b0011, 2'b00, 4'b1101, 1'b0);
        drive(4'b1010, 4'b0011, 2'b00, 4'b1101, 1'b0);
        n_total++; if (halted !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL halt_early: got halted=%b in_ready=%b required 0/1", halted, in_ready); else n_pass++;
        drive(4'b1010, 4'b0011, 2'b00, 4'b1101, 1'b0);
        n_total++; if (halted !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL halt_entry: got halted=%b in_ready=%b required 1/0", halted, in_ready); else n_pass++;
        idle();
        drain();
        n_total++; if (sb.size() != 0) $display("FAIL halt_drain: got %0d pending required 0", sb.size()); else n_pass++;
        n_total++; if (pass_cnt !== 8'd28 || fail_cnt !== 8'd1)
            $display("FAIL halt_counts: got %0d/%0d required 28/1", pass_cnt, fail_cnt); else n_pass++;
        n_total++; if (ff_vec !== 16'b1010_0011_01_0111_0_0)
            $display("FAIL ff_vec_first: got %h required %h", ff_vec, 16'b1010_0011_01_0111_0_0); else n_pass++;
    endtask

    task automatic test_halt_clr();
        for (int i = 0; i < 5; i++) drive(4'(i), 4'd3, 2'b00, 4'd0, 1'b1);
        idle();
        drain();
        n_total++; if (pass_cnt !== 8'd28 || fail_cnt !== 8'd1 || halted !== 1'b1)
            $display("FAIL halt_frozen: got %0d/%0d halted=%b required 28/1 halted=1", pass_cnt, fail_cnt, halted); else n_pass++;
        pulse_clr();
        n_total++; if (in_ready !== 1'b1 || halted !== 1'b0 || chk_valid !== 1'b0 || chk_fail !== 1'b0)
            $display("FAIL clr_flags: got rdy=%b halted=%b vld=%b fail=%b required 1/0/0/0",
                     in_ready, halted, chk_valid, chk_fail); else n_pass++;
        n_total++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0 || ff_vec !== 16'h0)
            $display("FAIL clr_state: got %0d/%0d ff_vec=%h required 0/0/0000", pass_cnt, fail_cnt, ff_vec); else n_pass++;
    endtask

    task automatic test_drop();
        int seen;
        seen = 0;
        @(negedge clk);
        A = 4'd5; B = 4'd2; S = 2'b00; C = 4'd7; Co = 1'b0;
        in_valid = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (chk_valid === 1'b1) seen++;
        end
        n_total++; if (seen != 0 || pass_cnt !== 8'd0)
            $display("FAIL drop_on_clr: got pulses=%0d pass_cnt=%0d required 0/0", seen, pass_cnt); else n_pass++;
    endtask

    task automatic test_rst_inflight();
        int seen;
        seen = 0;
        drive(4'd4, 4'd4, 2'b01, 4'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (chk_valid === 1'b1) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL rst_inflight_pulse: got %0d pulses required 0", seen); else n_pass++;
        n_total++; if (pass_cnt !== 8'd0 || fail_cnt !== 8'd0)
            $display("FAIL rst_inflight_counts: got %0d/%0d required 0/0", pass_cnt, fail_cnt); else n_pass++;
    endtask

    task automatic test_saturate();
        pulse_clr();
        for (int i = 0; i < 300; i++) drive(4'(i + 1), 4'hf, 2'b10, 4'(i + 1), 1'b1);
        idle();
        drain();
        n_total++; if (nh_fail_cnt !== 8'd255 || nh_pass_cnt !== 8'd0)
            $display("FAIL sat_counts: got %0d/%0d required 0/255", nh_pass_cnt, nh_fail_cnt); else n_pass++;
        n_total++; if (nh_halted !== 1'b0 || nh_in_ready !== 1'b1)
            $display("FAIL sat_no_halt: got halted=%b in_ready=%b required 0/1", nh_halted, nh_in_ready); else n_pass++;
        n_total++; if (nh_ff_vec !== 16'b0001_1111_10_0001_1_0)
            $display("FAIL sat_ff_vec: got %h required %h", nh_ff_vec, 16'b0001_1111_10_0001_1_0); else n_pass++;
        n_total++; if (fail_cnt !== 8'd4 || halted !== 1'b1)
            $display("FAIL stop_drain_count: got fail_cnt=%0d halted=%b required 4/1", fail_cnt, halted); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_fail_halt();
        test_halt_clr();
        test_drop();
        test_rst_inflight();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
